// File: rtl/ovl_sem_pkg.sv
// Shared types for the OVL fire monitor: FSM state encoding, the counter width
// and the saturating-increment helper.
package ovl_sem_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ovl_sem_sat_counter.sv
// Counter of width CNT_W with synchronous clear and increment. It holds at its
// maximum value rather than wrapping.
module ovl_sem_sat_counter
    import ovl_sem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ovl_sem_fire_monitor.sv
// Observes an OVL checker fire vector for WINDOW_CYCLES cycles after each start
// and reports a pass/fail verdict. Define OVL_SEM_FIRE_FIRST_CYCLE_EN to capture
// the index of the first firing cycle.
module ovl_sem_fire_monitor
    import ovl_sem_pkg::*;
#(
    parameter int FIRE_WIDTH    = 3,
    parameter int WINDOW_CYCLES = 8,
    parameter int EXPECT_FIRE   = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [FIRE_WIDTH-1:0] fire_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [FIRE_WIDTH-1:0] fire_seen_o,
    output logic [CNT_W-1:0]      fire_count_o,
    output logic [CNT_W-1:0]      first_fire_cycle_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        run_cnt_q, run_cnt_d;
    logic [FIRE_WIDTH-1:0]   fire_seen_q, fire_seen_d;
    logic [FIRE_WIDTH-1:0]   fire_clean;
    logic                    any_fire;
    logic                    run_clr;
    logic                    cnt_inc;

    // Unknown or high-impedance fire bits are conservatively counted as firing.
    genvar gi;
    generate
        for (gi = 0; gi < FIRE_WIDTH; gi++) begin : g_fire_clean
            assign fire_clean[gi] = (fire_i[gi] !== 1'b0);
        end
    endgenerate

    assign any_fire = |fire_clean;

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        fire_seen_d = fire_seen_q;
        run_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = RUN;
                    run_cnt_d   = '0;
                    fire_seen_d = '0;
                    run_clr     = 1'b1;
                end
            end
            RUN: begin
                fire_seen_d = fire_seen_q | fire_clean;
                cnt_inc     = any_fire;
                run_cnt_d   = run_cnt_q + 1'b1;
                if (run_cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            fire_seen_q <= '0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            fire_seen_q <= fire_seen_d;
        end
    end

    ovl_sem_sat_counter u_fire_count (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .clr_i   (run_clr),
        .inc_i   (cnt_inc),
        .count_o (fire_count_o)
    );

`ifdef OVL_SEM_FIRE_FIRST_CYCLE_EN
    logic [CNT_W-1:0] first_q, first_d;

    // An empty fire_seen means no earlier cycle of this run has fired.
    always_comb begin
        first_d = first_q;
        if (run_clr) begin
            first_d = '0;
        end else if ((state_q == RUN) && any_fire && (fire_seen_q == '0)) begin
            first_d = run_cnt_q;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            first_q <= '0;
        end else begin
            first_q <= first_d;
        end
    end

    assign first_fire_cycle_o = first_q;
`else
    assign first_fire_cycle_o = '0;
`endif

    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign pass_o      = done_o & ((|fire_seen_q) == (EXPECT_FIRE != 0));
    assign fire_seen_o = fire_seen_q;

endmodule

// File: tb/tb_ovl_sem_fire_monitor.sv
// Randomized self-checking bench: three monitor instances (defaults, EXPECT_FIRE=1,
// WINDOW_CYCLES=255) share clock, reset and fire; each run is scored from its fire pattern.
module tb_ovl_sem_fire_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] fire;
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [2:0] seen  [3];
    logic [7:0] cnt   [3];
    logic [7:0] first [3];

    logic [2:0] pat [0:254];
    int tests_run;
    int tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ovl_sem_fire_monitor #(.FIRE_WIDTH(3), .WINDOW_CYCLES(8), .EXPECT_FIRE(0)) u_dut0 (
        .clock_i(clk), .reset_i(rst), .start_i(start[0]), .fire_i(fire),
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .fire_seen_o(seen[0]),
        .fire_count_o(cnt[0]), .first_fire_cycle_o(first[0]));

    ovl_sem_fire_monitor #(.FIRE_WIDTH(3), .WINDOW_CYCLES(8), .EXPECT_FIRE(1)) u_dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start[1]), .fire_i(fire),
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .fire_seen_o(seen[1]),
        .fire_count_o(cnt[1]), .first_fire_cycle_o(first[1]));

    ovl_sem_fire_monitor #(.FIRE_WIDTH(3), .WINDOW_CYCLES(255), .EXPECT_FIRE(0)) u_dut2 (
        .clock_i(clk), .reset_i(rst), .start_i(start[2]), .fire_i(fire),
        .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .fire_seen_o(seen[2]),
        .fire_count_o(cnt[2]), .first_fire_cycle_o(first[2]));

    function automatic int win_of(input int inst);
        return (inst == 2) ? 255 : 8;
    endfunction

    function automatic int exp_of(input int inst);
        return (inst == 1) ? 1 : 0;
    endfunction

    task automatic clear_pat();
        for (int k = 0; k < 255; k++) pat[k] = 3'b000;
    endtask

    // One complete run on instance inst using pat[]; start_at >= 0 re-pulses start mid-run.
    task automatic do_run(input int inst, input int start_at, input string name);
        int         win;
        int         exp_cnt;
        int         exp_first;
        bit         got;
        bit         exp_pass;
        logic [2:0] exp_seen;
        win       = win_of(inst);
        exp_cnt   = 0;
        exp_first = 0;
        got       = 1'b0;
        exp_seen  = 3'b000;
        for (int k = 0; k < win; k++) begin
            if (pat[k] != 3'b000) begin
                exp_seen = exp_seen | pat[k];
                if (!got) exp_first = k;
                got = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
        end
`ifndef OVL_SEM_FIRE_FIRST_CYCLE_EN
        exp_first = 0;
`endif
        exp_pass = ((exp_seen != 3'b000) == (exp_of(inst) != 0));

        @(negedge clk);
        start[inst] = 1'b1;
        fire        = 3'b000;
        @(negedge clk);
        start[inst] = 1'b0;
        tests_run++;
        if (busy[inst] !== 1'b1 || done[inst] !== 1'b0 || pass[inst] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s run_entry: busy=%b done=%b pass=%b, required busy=1 done=0 pass=0",
                     name, busy[inst], done[inst], pass[inst]);
        end
        for (int k = 0; k < win; k++) begin
            fire         = pat[k];
            start[inst]  = (k == start_at);
            if (k == win - 1) begin
                tests_run++;
                if (done[inst] !== 1'b0 || busy[inst] !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL %s early_done: busy=%b done=%b before last sample, required busy=1 done=0",
                             name, busy[inst], done[inst]);
                end
            end
            @(negedge clk);
        end
        fire        = 3'b000;
        start[inst] = 1'b0;

        tests_run++;
        if (done[inst] !== 1'b1 || busy[inst] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s completion: busy=%b done=%b, required busy=0 done=1",
                     name, busy[inst], done[inst]);
        end
        tests_run++;
        if (pass[inst] !== exp_pass) begin
            tests_failed++;
            $display("[TB] FAIL %s pass: got %b, required %b", name, pass[inst], exp_pass);
        end
        tests_run++;
        if (seen[inst] !== exp_seen) begin
            tests_failed++;
            $display("[TB] FAIL %s fire_seen: got %b, required %b", name, seen[inst], exp_seen);
        end
        tests_run++;
        if (cnt[inst] !== 8'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL %s fire_count: got %0d, required %0d", name, cnt[inst], exp_cnt);
        end
        tests_run++;
        if (first[inst] !== 8'(exp_first)) begin
            tests_failed++;
            $display("[TB] FAIL %s first_fire_cycle: got %0d, required %0d", name, first[inst], exp_first);
        end
        $display("[TB] %s inst=%0d win=%0d seen=%b count=%0d first=%0d pass=%b",
                 name, inst, win, seen[inst], cnt[inst], first[inst], pass[inst]);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || pass[i] !== 1'b0 ||
                seen[i] !== 3'b000 || cnt[i] !== 8'd0 || first[i] !== 8'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_state inst=%0d: busy=%b done=%b pass=%b seen=%b cnt=%0d first=%0d, required all 0",
                         i, busy[i], done[i], pass[i], seen[i], cnt[i], first[i]);
            end
        end
        $display("[TB] test_reset: reset state checked on all instances");
    endtask

    task automatic test_idle_pass();
        clear_pat();
        do_run(0, -1, "idle_pass");
    endtask

    task automatic test_single_fire();
        clear_pat();
        pat[1] = 3'b001;
        do_run(0, -1, "single_fire");
    endtask

    task automatic test_last_cycle_fire();
        clear_pat();
        pat[7] = 3'b100;
        do_run(1, -1, "last_cycle_fire");
    endtask

    task automatic test_long_window();
        for (int k = 0; k < 255; k++) pat[k] = 3'b010;
        do_run(2, -1, "long_window");
    endtask

    task automatic test_mid_run_reset();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        fire = 3'b000;
        @(negedge clk);
        fire = 3'b001;
        @(negedge clk);
        fire = 3'b000;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0 ||
            seen[0] !== 3'b000 || cnt[0] !== 8'd0 || first[0] !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_run_reset: busy=%b done=%b pass=%b seen=%b cnt=%0d first=%0d, required all 0",
                     busy[0], done[0], pass[0], seen[0], cnt[0], first[0]);
        end
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL start_during_reset: busy=%b done=%b, required busy=0 done=0",
                     busy[0], done[0]);
        end
        $display("[TB] test_mid_run_reset: async reset applied on run cycle 3");
        clear_pat();
        do_run(0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        clear_pat();
        pat[2] = 3'b110;
        do_run(0, 4, "start_in_run");
        clear_pat();
        pat[5] = 3'b011;
        pat[6] = 3'b001;
        do_run(0, -1, "restart_from_done");
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int inst;
            int density;
            inst    = (r % 4 == 3) ? 2 : r % 2;
            density = $urandom_range(0, 3);
            clear_pat();
            for (int k = 0; k < win_of(inst); k++) begin
                if (density != 0 && $urandom_range(0, 3) < density)
                    pat[k] = 3'($urandom_range(1, 7));
            end
            do_run(inst, (r % 3 == 0) ? int'($urandom_range(0, 6)) : -1, "random");
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 3'b000;
        fire  = 3'b000;
        clear_pat();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_idle_pass();
        test_single_fire();
        test_last_cycle_fire();
        test_long_window();
        test_mid_run_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ovl_sem_fire_monitor.md
OVL_SEM_FIRE_MONITOR -- requirements
Module: ovl_sem_fire_monitor

Interface
REQ-001 Parameter FIRE_WIDTH, default 3: width of the checker fire vector (matches OVL fire width).
REQ-002 Parameter WINDOW_CYCLES, default 8, range 1..255: number of observation cycles per run.
REQ-003 Parameter EXPECT_FIRE, default 0: 1 = run passes only if a fire occurs; 0 = run passes only if no fire occurs.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a run.
REQ-007 fire  input  FIRE_WIDTH  fire vector from the OVL checker under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high once a run has completed; holds until the next accepted start.
REQ-010 pass  output  1  verdict; valid only while done=1.
REQ-011 fire_seen  output  FIRE_WIDTH  sticky OR of every fire vector sampled during the run.
REQ-012 fire_count  output  8  number of run cycles with any fire bit set, saturating at 255.
REQ-013 first_fire_cycle  output  8  run-cycle index (0-based) of the first fire.

Function
REQ-014 FSM states: IDLE, RUN, DONE; reset enters IDLE.
REQ-015 IDLE->RUN when start=1 at a clock edge; DONE->RUN likewise; start in RUN is ignored.
REQ-016 Entering RUN clears fire_seen, fire_count, first_fire_cycle and the 8-bit run counter to 0, and clears done.
REQ-017 In RUN, each clock samples fire: fire_seen |= fire; fire_count increments if |fire, holding at 255.
REQ-018 The run counter increments once per RUN cycle; the cycle on which the counter equals WINDOW_CYCLES-1 is the last sampled cycle, after which the FSM enters DONE.
REQ-019 Exactly WINDOW_CYCLES fire samples are taken per run; the start cycle itself is not sampled.
REQ-020 busy = (state==RUN); done = (state==DONE); both are registered state decodes.
REQ-021 pass = done & ((|fire_seen) == EXPECT_FIRE); pass is 0 outside DONE.
REQ-022 fire with X/Z bits is treated as fire (counts as set).
REQ-023 Fire arriving on the last sampled cycle is included in the verdict.

Reset
REQ-024 Reset asserted at any time, including mid-run, forces IDLE immediately; busy, done, pass, fire_seen, fire_count, first_fire_cycle and the run counter all go to 0.
REQ-025 start coincident with reset release is ignored; the first start accepted is on a clock edge with reset low.

Configuration
REQ-026 Macro OVL_SEM_FIRE_FIRST_CYCLE_EN compiles in first-fire capture.
REQ-027 With the macro: on the first RUN cycle where |fire=1 and no earlier fire in this run, first_fire_cycle latches the run counter value; it holds thereafter until the next start.
REQ-028 Without the macro: first_fire_cycle is constant 0 and no capture register exists; all other behaviour is unchanged.

Structure
REQ-029 Package ovl_sem_pkg holds the FSM state enum (IDLE, RUN, DONE) and the 8-bit counter width constant.
REQ-030 One sub-module, ovl_sem_sat_counter (8-bit saturating counter with clear and increment), is used for fire_count; the run counter is inline.

Verification
REQ-031 Defaults, start pulse, fire=0 for all 8 cycles -> done=1 after 8 sampled cycles, pass=1, fire_count=0, fire_seen=3'b000.
REQ-032 Defaults, fire=3'b001 on run cycle 1 only -> pass=0, fire_count=1, fire_seen=3'b001, first_fire_cycle=1 (macro on) / 0 (macro off).
REQ-033 EXPECT_FIRE=1, fire=3'b100 on the last run cycle (7) only -> pass=1, fire_count=1, first_fire_cycle=7.
REQ-034 WINDOW_CYCLES=255, fire=3'b010 on all 255 cycles -> fire_count=255, no wrap, pass=0.
REQ-035 Reset asserted on run cycle 3 after a fire -> all outputs 0 immediately, state IDLE; a new start then gives a clean run with fire_count=0.
REQ-036 start pulsed during RUN at cycle 4 -> ignored; done still rises after 8 sampled cycles from the original start; start in DONE re-runs and clears done for the run duration.
